pc_ir_unit: RTL
===============

# pc_ir_unit

Program-counter and instruction-register stage that sits directly upstream of the multicycle control unit. On the control unit's `IRWrite` fetch request it runs a request/acknowledge transaction to instruction memory and latches the returned 16-bit word into IR. It exposes `op` (IR[15:12]) and the full IR to the control unit and datapath, and updates PC under `PCWriteEnable`/`PCSource`. A stuck memory is caught by a fetch timeout that raises a sticky fault.

## Interface
- `ADDR_W`, 16, PC and instruction-address width.
- `INSTR_W`, 16, instruction width; `op` is always the top 4 bits.
- `RESET_PC`, 0, PC value after reset.
- `TIMEOUT`, 255, maximum number of cycles spent in REQ without an ack before a fault is raised; must be ≥1.

Ports:
- `CLK` in 1: clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `IRWrite` in 1: fetch request from the control unit, level-sampled.
- `PCWriteEnable` in 1: PC load enable.
- `PCSource` in 1: 0 selects `pc_alu`, 1 selects `pc_target`.
- `pc_alu` in ADDR_W: ALU result (PC+offset path).
- `pc_target` in ADDR_W: branch/JALR target.
- `imem_req` out 1: memory read request.
- `imem_addr` out ADDR_W: request address.
- `imem_ack` in 1: memory data valid.
- `imem_rdata` in INSTR_W: instruction word.
- `ir` out INSTR_W: instruction register.
- `op` out 4: `ir[INSTR_W-1 -: 4]`.
- `pc` out ADDR_W: program counter.
- `fetch_busy` out 1: high in REQ and LATCH.
- `fetch_done` out 1: one-cycle pulse when IR is updated.
- `fault` out 1: sticky fetch timeout.

## Operation
- FSM states: IDLE, REQ, LATCH, FAULT. All outputs are Moore/registered.
- IDLE: if `IRWrite`=1 at a clock edge, capture `pc` into the address register and go to REQ.
- REQ: `imem_req`=1 and `imem_addr` is held stable.
  - If `imem_ack`=1 at the edge: `ir`←`imem_rdata`, go to LATCH.
  - Else if the timer equals TIMEOUT-1: go to FAULT.
  - Else: increment the timer.
- LATCH: `fetch_done`=1 for one cycle, then IDLE. The timer clears.
- FAULT: `fault`=1, `imem_req`=0, `IRWrite` is ignored. Only `Reset` exits FAULT.
- `IRWrite` outside IDLE is ignored, not queued.
- `imem_ack` outside REQ is ignored. This covers late acks after a fault or after reset.
- PC update is independent of the FSM: on any edge with `PCWriteEnable`=1, `pc`←`PCSource`?`pc_target`:`pc_alu`.
  - Arithmetic is modulo 2^ADDR_W; no overflow detection.
  - A PC write during REQ does not change `imem_addr`; the in-flight fetch completes from the captured address.
- Timer width is $clog2(TIMEOUT+1).

## Timing
- Reset values: `pc`=RESET_PC, `ir`=0, `op`=0, `imem_req`=0, `imem_addr`=RESET_PC, `fetch_busy`=0, `fetch_done`=0, `fault`=0, state IDLE, timer 0.
- Minimum latency with zero-wait memory:
  - cycle 0: `IRWrite` sampled.
  - cycle 1: `imem_req`=1 and `imem_ack`=1.
  - cycle 2: `ir`/`op` hold the new value and `fetch_done`=1.
- With N wait cycles, `fetch_done` arrives at cycle 2+N.
- Fault: `fault` rises TIMEOUT cycles after `imem_req` first rose, and `imem_req` drops in the same cycle.
- `Reset` mid-fetch: `imem_req` drops asynchronously and IR keeps its reset value; the aborted fetch is never completed.
- `IRWrite` and `PCWriteEnable` on the same edge in IDLE: the fetch uses the old PC, and the new PC is visible the next cycle.

## Configuration
- `PC_IR_INSTR_COUNT_EN` defined:
  - Adds output `instr_count` (32 bits, reset 0).
  - Increments by 1 on every IDLE→…→LATCH completion, counted at the LATCH cycle.
  - Wraps at 2^32 and does not count faulted fetches.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Package `pc_ir_pkg` holds:
  - the state enum;
  - the `OP_MSB` and `OP_W`=4 constants;
  - opcode constants shared with the control unit: `OP_ADD`=0000, `OP_SUB`=0001, `OP_XOR`=0010, `OP_OR`=0011, `OP_AND`=0100, `OP_TST`=0101, `OP_LW`=0110, `OP_SW`=0111, `OP_BEQ`=1000, `OP_BGE`=1001, `OP_BLT`=1010, `OP_JALR`=1011, `OP_ADDI`=1100, `OP_SRLI`=1101, `OP_SLLI`=1110, `OP_LUI`=1111.
- One sub-module, `fetch_timer`: a clearable saturating counter with an `expired` output compared against TIMEOUT.

## Test plan
- Zero-wait fetch: reset, `IRWrite` 1 cycle, ack in the same cycle as req with `imem_rdata`=0x5A3C → at cycle 2 `ir`=0x5A3C, `op`=0x5, `fetch_done` pulses once, `imem_addr` was 0.
- Wait states: ack delayed 3 cycles, `imem_rdata`=0xF012 → `imem_req` high for 4 cycles, `imem_addr` stable, `fetch_done` at cycle 5.
- PC mux during fetch: in REQ, `PCWriteEnable`=1, `PCSource`=1, `pc_target`=0x0040 → `imem_addr` stays 0, `pc`=0x0040; the next fetch uses 0x0040. Also check `pc_alu`=0xFFFE+2 wrap → `pc`=0x0000.
- Timeout: TIMEOUT=4, no ack → `fault` high at req+4 cycles, later `IRWrite` and ack ignored, `Reset` clears `fault`.
- Reset mid-REQ, then a late ack → `imem_req` drops immediately, `ir`=0, no `fetch_done`.
- With `PC_IR_INSTR_COUNT_EN`: 3 successful fetches and 1 faulted fetch → `instr_count`=3.

Source files
------------

// File: rtl/pc_ir_unit_pkg.sv
// Shared definitions for the PC/IR fetch stage: FSM state encoding and the
// opcode field layout/values also decoded by the multicycle control unit.
package pc_ir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_LATCH = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    localparam int OP_W   = 4;
    localparam int OP_MSB = 15;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0100;
    localparam logic [OP_W-1:0] OP_TST  = 4'b0101;
    localparam logic [OP_W-1:0] OP_LW   = 4'b0110;
    localparam logic [OP_W-1:0] OP_SW   = 4'b0111;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'b1000;
    localparam logic [OP_W-1:0] OP_BGE  = 4'b1001;
    localparam logic [OP_W-1:0] OP_BLT  = 4'b1010;
    localparam logic [OP_W-1:0] OP_JALR = 4'b1011;
    localparam logic [OP_W-1:0] OP_ADDI = 4'b1100;
    localparam logic [OP_W-1:0] OP_SRLI = 4'b1101;
    localparam logic [OP_W-1:0] OP_SLLI = 4'b1110;
    localparam logic [OP_W-1:0] OP_LUI  = 4'b1111;

endpackage

// File: rtl/pc_ir_unit_fetch_timer.sv
// Clearable saturating cycle counter; expired_o flags the last permitted
// REQ cycle so the FSM can fault on that edge if no ack arrives.
module fetch_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] SAT  = TW'(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != SAT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/pc_ir_unit.sv
// PC and instruction-register fetch stage with req/ack memory handshake and
// sticky timeout fault. Optional retired-fetch counter: PC_IR_INSTR_COUNT_EN.
module pc_ir_unit
    import pc_ir_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter int          INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int          TIMEOUT  = 255
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               IRWrite,
    input  logic               PCWriteEnable,
    input  logic               PCSource,
    input  logic [ADDR_W-1:0]  pc_alu,
    input  logic [ADDR_W-1:0]  pc_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [OP_W-1:0]    op,
    output logic [ADDR_W-1:0]  pc,
    output logic               fetch_busy,
    output logic               fetch_done,
    output logic               fault,
    output logic [1:0]         dbg_state
`ifdef PC_IR_INSTR_COUNT_EN
    ,
    output logic [31:0]        instr_count
`endif
);

    // Handshake: imem_req stays high with imem_addr stable until the first
    // edge where imem_ack is seen in REQ; acks in any other state are dropped.

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               tmr_expired;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (IRWrite) state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ack) begin
                    state_d = ST_LATCH;
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_LATCH: state_d = ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        ir_d   = ir_q;
        pc_d   = pc_q;
        // Address is frozen at fetch start so PC writes cannot disturb REQ.
        if (state_q == ST_IDLE && IRWrite) addr_d = pc_q;
        if (state_q == ST_REQ && imem_ack) ir_d = imem_rdata;
        if (PCWriteEnable) pc_d = PCSource ? pc_target : pc_alu;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_RST;
            addr_q  <= PC_RST;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
        end
    end

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK       (CLK),
        .Reset     (Reset),
        .clear_i   (state_q != ST_REQ),
        .en_i      (state_q == ST_REQ),
        .expired_o (tmr_expired)
    );

    assign imem_req   = (state_q == ST_REQ);
    assign imem_addr  = addr_q;
    assign ir         = ir_q;
    assign op         = ir_q[INSTR_W-1 -: OP_W];
    assign pc         = pc_q;
    assign fetch_busy = (state_q == ST_REQ) || (state_q == ST_LATCH);
    assign fetch_done = (state_q == ST_LATCH);
    assign fault      = (state_q == ST_FAULT);
    assign dbg_state  = state_q;

`ifdef PC_IR_INSTR_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_LATCH) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_count = cnt_q;
`endif

endmodule
